// File: rtl/alu_host_driver.sv
// Initiator for the ALU16 operand/result bus: sequences start/s/inbus, captures outbus words and flags.
// Latency: start 1 cycle after request accept, response 1 cycle after finish; rsp_* held until rsp_ready.
module alu_host_driver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ABORT_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_x,
  input  logic [15:0] req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_hi,
  output logic [15:0] rsp_lo,
  output logic [3:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        alu_start,
  output logic [1:0]  alu_s,
  output logic [15:0] alu_inbus,
  input  logic [15:0] alu_outbus,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_finish,
  output logic        alu_rst_b
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LOAD_X, S_LOAD_Y, S_WAIT, S_ABORT, S_RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] AB_LAST = 8'(ABORT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] hist0_q, hist0_d, hist1_q, hist1_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        alu_start_q, alu_start_d;
  logic [1:0]  alu_s_q, alu_s_d;
  logic [15:0] alu_inbus_q, alu_inbus_d;
  logic        alu_rst_b_q, alu_rst_b_d;

  // Each transition loads the outputs of the state being entered, so every output is a flop.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    hist0_d       = hist0_q;
    hist1_d       = hist1_q;
    cnt_d         = cnt_q;
    sticky_d      = sticky_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_hi_d      = rsp_hi_q;
    rsp_lo_d      = rsp_lo_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    alu_start_d   = alu_start_q;
    alu_s_d       = alu_s_q;
    alu_inbus_d   = alu_inbus_q;
    alu_rst_b_d   = alu_rst_b_q;
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          x_d         = req_x;
          y_d         = req_y;
          alu_s_d     = req_op;
          alu_start_d = 1'b1;
          alu_inbus_d = 16'h0000;
          req_ready_d = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        alu_start_d = 1'b0;
        alu_inbus_d = x_q;
        state_d     = S_LOAD_X;
      end
      S_LOAD_X: begin
        alu_inbus_d = y_q;
        state_d     = S_LOAD_Y;
      end
      S_LOAD_Y: begin
        alu_inbus_d = 16'h0000;
        cnt_d       = 8'd0;
        sticky_d    = 1'b0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        hist1_d  = hist0_q;
        hist0_d  = alu_outbus;
        sticky_d = sticky_q | alu_overflow;
        cnt_d    = cnt_q + 8'd1;
        // finish takes priority over the watchdog limit
        if (alu_finish) begin
          rsp_hi_d      = hist1_q;
          rsp_lo_d      = hist0_q;
          rsp_flags_d   = {alu_negative, alu_zero, alu_carry, sticky_q | alu_overflow};
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          alu_rst_b_d = 1'b0;
          cnt_d       = 8'd0;
          state_d     = S_ABORT;
        end
      end
      S_ABORT: begin
        if (cnt_q == AB_LAST) begin
          alu_rst_b_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_hi_d      = 16'h0000;
          rsp_lo_d      = 16'h0000;
          rsp_flags_d   = 4'h0;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x_q           <= 16'h0000;
      y_q           <= 16'h0000;
      hist0_q       <= 16'h0000;
      hist1_q       <= 16'h0000;
      cnt_q         <= 8'd0;
      sticky_q      <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_hi_q      <= 16'h0000;
      rsp_lo_q      <= 16'h0000;
      rsp_flags_q   <= 4'h0;
      rsp_timeout_q <= 1'b0;
      alu_start_q   <= 1'b0;
      alu_s_q       <= 2'b00;
      alu_inbus_q   <= 16'h0000;
      alu_rst_b_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hist0_q       <= hist0_d;
      hist1_q       <= hist1_d;
      cnt_q         <= cnt_d;
      sticky_q      <= sticky_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hi_q      <= rsp_hi_d;
      rsp_lo_q      <= rsp_lo_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
      alu_start_q   <= alu_start_d;
      alu_s_q       <= alu_s_d;
      alu_inbus_q   <= alu_inbus_d;
      alu_rst_b_q   <= alu_rst_b_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_hi      = rsp_hi_q;
  assign rsp_lo      = rsp_lo_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_timeout = rsp_timeout_q;
  assign alu_start   = alu_start_q;
  assign alu_s       = alu_s_q;
  assign alu_inbus   = alu_inbus_q;
  assign alu_rst_b   = alu_rst_b_q;

endmodule

// File: tb/tb_alu_host_driver.sv
// Directed bench for alu_host_driver: the bench plays the ALU16 side with hand-chosen bus timing.
module tb_alu_host_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_x = 16'h0000;
  logic [15:0] req_y = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_hi, rsp_lo;
  logic [3:0]  rsp_flags;
  logic        rsp_timeout;
  logic        alu_start;
  logic [1:0]  alu_s;
  logic [15:0] alu_inbus;
  logic [15:0] alu_outbus = 16'h0000;
  logic        alu_negative = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_carry = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        alu_finish = 1'b0;
  logic        alu_rst_b;

  int checks = 0;
  int failures = 0;
  bit rstb_low_seen = 1'b0;

  alu_host_driver #(.TIMEOUT_CYCLES(64), .ABORT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .alu_start(alu_start), .alu_s(alu_s), .alu_inbus(alu_inbus), .alu_outbus(alu_outbus),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_finish(alu_finish), .alu_rst_b(alu_rst_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (alu_rst_b !== 1'b1) rstb_low_seen = 1'b1;
  endtask

  // Accept a request and follow the start/M/Q load sequence into the first WAIT cycle.
  task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    step();
    req_valid = 1'b0; req_x = 16'hA5A5; req_y = 16'h5A5A;
    chk("start_pulse", 32'(alu_start), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    chk("alu_s", 32'(alu_s), 32'(op));
    chk("inbus_start", 32'(alu_inbus), 32'd0);
    step();
    chk("load_x", {15'd0, alu_start, alu_inbus}, {15'd0, 1'b0, x});
    step();
    chk("load_y", 32'(alu_inbus), 32'(y));
    step();
    chk("inbus_wait", 32'(alu_inbus), 32'd0);
    chk("req_ready_wait", 32'(req_ready), 32'd0);
  endtask

  // ALU side: A on cycle f-2, Q on f-1, finish and n/z/c on cycle f; other cycles carry decoy values.
  task automatic alu_run(input int f, input logic [15:0] a, input logic [15:0] q,
                         input logic [2:0] nzc, input int ovf_cyc, input bit ovf_fin);
    for (int j = 0; j <= f; j++) begin
      alu_outbus   = (j == f - 2) ? a : (j == f - 1) ? q : 16'hBEEF;
      alu_overflow = (j == ovf_cyc) || (j == f && ovf_fin);
      alu_finish   = (j == f);
      {alu_negative, alu_zero, alu_carry} = (j == f) ? nzc : ~nzc;
      step();
    end
    alu_outbus = 16'h0000; alu_overflow = 1'b0; alu_finish = 1'b0;
    {alu_negative, alu_zero, alu_carry} = 3'b000;
  endtask

  task automatic check_rsp(input logic [15:0] hi, input logic [15:0] lo, input logic [3:0] flags,
                           input logic to, input int bp);
    bit stable;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_hi", 32'(rsp_hi), 32'(hi));
    chk("rsp_lo", 32'(rsp_lo), 32'(lo));
    chk("rsp_flags", 32'(rsp_flags), 32'(flags));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(to));
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_hi !== hi || rsp_lo !== lo || rsp_flags !== flags ||
          rsp_timeout !== to || req_ready !== 1'b0) stable = 1'b0;
    end
    if (bp > 0) chk("rsp_hold", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_ret", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    bit quiet;
    #12 rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", {alu_start, alu_s, alu_inbus, rsp_valid, rsp_timeout, rsp_flags},
        32'd0);
    chk("rst_rsp_data", {rsp_hi, rsp_lo}, 32'd0);
    chk("rst_alu_rst_b", 32'(alu_rst_b), 32'd1);

    // Add: 5 + 3, finish six edges after LOAD_Y
    rstb_low_seen = 1'b0;
    issue(2'b00, 16'h0005, 16'h0003);
    alu_run(5, 16'h0000, 16'h0008, 3'b000, -1, 1'b0);
    check_rsp(16'h0000, 16'h0008, 4'b0000, 1'b0, 0);

    // Multiply with 5 cycles of response backpressure
    issue(2'b10, 16'h0100, 16'h0100);
    alu_run(5, 16'h0001, 16'h0000, 3'b000, -1, 1'b0);
    check_rsp(16'h0001, 16'h0000, 4'b0000, 1'b0, 5);

    // Overflow pulse mid-WAIT must stick until finish
    issue(2'b00, 16'h7FFF, 16'h0001);
    alu_run(5, 16'h0000, 16'h8000, 3'b100, 2, 1'b0);
    check_rsp(16'h0000, 16'h8000, 4'b1001, 1'b0, 0);
    chk("no_abort_normal", 32'(rstb_low_seen), 32'd0);

    // Timeout: no finish for 64 WAIT cycles
    issue(2'b01, 16'h1111, 16'h2222);
    alu_outbus = 16'hBEEF;
    for (int j = 0; j < 63; j++) step();
    chk("no_abort_early", {alu_rst_b, rsp_valid}, {30'd0, 2'b10});
    step();
    chk("abort_entry", 32'(alu_rst_b), 32'd0);
    n = 1;
    while (alu_rst_b !== 1'b1 && n < 20) begin
      step();
      if (alu_rst_b !== 1'b1) n++;
    end
    chk("abort_len", 32'(n), 32'd2);
    alu_outbus = 16'h0000;
    check_rsp(16'h0000, 16'h0000, 4'b0000, 1'b1, 0);

    // Finish on the same cycle the counter reaches its limit
    rstb_low_seen = 1'b0;
    issue(2'b11, 16'h00AA, 16'h0055);
    alu_run(63, 16'h1234, 16'h5678, 3'b011, -1, 1'b1);
    chk("simul_no_abort", 32'(rstb_low_seen), 32'd0);
    check_rsp(16'h1234, 16'h5678, 4'b0111, 1'b0, 0);

    // Asynchronous reset in the middle of WAIT
    issue(2'b11, 16'h0009, 16'h0007);
    alu_outbus = 16'hBEEF;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_outputs", {alu_start, alu_s, alu_inbus, rsp_valid, rsp_timeout, rsp_flags},
        32'd0);
    chk("arst_alu_rst_b", 32'(alu_rst_b), 32'd1);
    #2 rst = 1'b0;
    alu_finish = 1'b1;
    step();
    alu_finish = 1'b0;
    alu_outbus = 16'h0000;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid !== 1'b0 || alu_start !== 1'b0) quiet = 1'b0;
    end
    chk("arst_no_rsp", 32'(quiet), 32'd1);

    issue(2'b01, 16'h0010, 16'h0004);
    alu_run(3, 16'hFFFF, 16'hFFF4, 3'b110, -1, 1'b0);
    check_rsp(16'hFFFF, 16'hFFF4, 4'b1100, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_host_driver.md
Name: alu_host_driver

Overview:
- Initiator side of the ALU16 operand/result bus protocol. Accepts one operation request per transaction (op, two 16-bit operands) on a valid/ready port.
- Sequences start/s/inbus into the ALU, captures the two result words from outbus and the status flags, then returns them on a valid/ready response port.
- Sits between the processor control path and the ALU16 instance; includes a watchdog that aborts a hung ALU.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles spent in WAIT before abort (range 4..255).
- ABORT_CYCLES, 2, cycles alu_rst_b is held low on abort (range 1..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  driver can accept a request
- req_op  in  2  operation select, passed to ALU s
- req_x  in  16  first operand (loaded into ALU M)
- req_y  in  16  second operand (loaded into ALU Q)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_hi  out  16  result word 1 (ALU A half)
- rsp_lo  out  16  result word 2 (ALU Q half)
- rsp_flags  out  4  {negative, zero, carry, overflow}
- rsp_timeout  out  1  response is an abort; data fields are 0
- alu_start  out  1  to ALU start
- alu_s  out  2  to ALU s
- alu_inbus  out  16  to ALU inbus
- alu_outbus  in  16  from ALU outbus
- alu_negative, alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags
- alu_finish  in  1  from ALU finish
- alu_rst_b  out  1  active-low ALU reset, driven low only during abort

Behaviour:
- Reset (async on rst high):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_hi/rsp_lo/rsp_flags/rsp_timeout=0.
  - alu_start=0; alu_s=0; alu_inbus=0; alu_rst_b=1.
  - History registers, sticky overflow and watchdog counter cleared.
  - Reset mid-transaction discards the transaction and produces no response.
- All outputs are registered.
- Bus contract: the ALU samples inbus as M on the cycle after the start pulse and as Q on the following cycle. It drives the A half on outbus two cycles before finish rises and the Q half one cycle before.
- States:
  - IDLE: req_ready=1. On req_valid, latch op/x/y, go to START.
  - START: alu_start=1, alu_s=op, alu_inbus=0, go to LOAD_X.
  - LOAD_X: alu_start=0, alu_inbus=x, go to LOAD_Y.
  - LOAD_Y: alu_inbus=y, clear counter, go to WAIT.
  - WAIT:
    - alu_inbus=0. Every cycle shift hist1<=hist0, hist0<=alu_outbus, and sticky_ovf|=alu_overflow; counter increments.
    - On alu_finish: rsp_hi=hist1, rsp_lo=hist0 (the values captured on the two prior cycles). rsp_flags = {alu_negative, alu_zero, alu_carry} sampled this cycle, plus sticky_ovf|alu_overflow. rsp_timeout=0, rsp_valid=1, go to RESP.
    - Else if counter==TIMEOUT_CYCLES-1: go to ABORT.
  - ABORT:
    - alu_rst_b=0 for ABORT_CYCLES cycles, then 1.
    - Then present rsp_valid=1, rsp_timeout=1, rsp_hi=rsp_lo=rsp_flags=0, and go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid=1 and rsp_ready=0. On rsp_ready, drop rsp_valid, go to IDLE, req_ready=1 on the next cycle.
- Request handshake:
  - req_ready=0 in every state except IDLE.
  - A request is accepted only on the cycle req_valid&req_ready.
  - Back-to-back operation: minimum turnaround is one IDLE cycle.
- Latency: start is asserted 1 cycle after acceptance. Response is valid 1 cycle after the finish rise.
- finish asserted during START/LOAD_X/LOAD_Y: ignored (protocol error, no response change).
- finish and timeout in the same cycle: finish wins.
- rsp_valid never drops without rsp_ready.

Test Plan:
- Add: op=00, x=0x0005, y=0x0003; model raises finish 6 cycles after LOAD_Y with outbus 0x0000 then 0x0008. Expect alu_inbus 0x0005 then 0x0003; rsp_hi=0x0000, rsp_lo=0x0008, flags=0000, timeout=0.
- Multiply with backpressure: op=10, x=0x0100, y=0x0100; model result hi=0x0001, lo=0x0000; rsp_ready low 5 cycles. Expect rsp stable throughout, single handshake, req_ready=0 until the cycle after acceptance.
- Overflow sticky: op=00, x=0x7FFF, y=0x0001; model pulses alu_overflow for 1 cycle mid-WAIT. Expect rsp_flags[0]=1.
- Timeout: model never asserts finish, TIMEOUT_CYCLES=64. Expect ABORT after 64 WAIT cycles, alu_rst_b low exactly 2 cycles, then rsp_timeout=1 with all data 0.
- Simultaneous: finish on the cycle the counter hits the limit. Expect a normal response with rsp_timeout=0 and alu_rst_b never low.
- Reset mid-WAIT: assert rst asynchronously. Expect all outputs at reset values immediately and no rsp_valid afterward; a new request then completes normally.
